fp_round_pack: RTL and testbench

FP_ROUND_PACK -- requirements
Module: fp_round_pack

---
 rtl/fp_round_pack.sv | 165 ++++++++++++++++
 tb/tb_fp_round_pack.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
//   Rounds a normalized 24-bit significand (hidden one + 23-bit fraction, with
//   guard/round/sticky bits) to nearest-even and packs it with its biased
//   exponent into an IEEE-754 single-precision word. Results that overflow
//   become signed infinity; results that underflow flush to signed zero.
//
//   Four-state sequencer: IDLE (accept) -> ROUND -> ADJUST -> OUT (hold).
//
// Ports
//   clk        clock, rising edge
//   res        asynchronous active-low reset
//   in_valid   upstream pair available
//   in_ready   block accepts a pair this cycle (IDLE only)
//   mant_in    [27] sign, [26] hidden one, [25:3] fraction, [2:0] guard/round/sticky
//   exp_in     biased exponent, 10-bit two's complement
//   zero_in    result is exactly zero
//   out_valid  out_data/ovf/unf hold a result (OUT only)
//   out_ready  downstream accepts the result
//   out_data   IEEE-754 single-precision result
//   ovf        result overflowed to infinity
//   unf        result flushed to zero
// -----------------------------------------------------------------------------
module fp_round_pack (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] mant_in,
    input  logic [9:0]  exp_in,
    input  logic        zero_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        ADJUST = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Captured input pair
    logic [27:0]        mant_q;
    logic signed [9:0]  exp_q;
    logic               zero_q;

    // Rounded significand; bit 24 is the carry out of rounding
    logic [24:0]        m25_q;

    // Result registers
    logic [31:0]        data_q;
    logic               ovf_q;
    logic               unf_q;

    // ---------------------------------------------------------------- next state
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ROUND;
            ROUND:   state_nxt = ADJUST;
            ADJUST:  state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- rounding
    // Round to nearest, ties to even: increment when guard is set and either
    // something below it is set or the kept LSB is odd.
    logic        rup;
    logic [24:0] m25;

    always_comb begin
        rup = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        m25 = {1'b0, mant_q[26:3]} + {24'd0, rup};
    end

    // ---------------------------------------------------------------- adjust / pack
    logic               carry;
    logic [22:0]        frac;
    logic signed [9:0]  e;
    logic [31:0]        res_data;
    logic               res_ovf;
    logic               res_unf;

    always_comb begin
        carry    = m25_q[24];
        // A rounding carry can only come from an all-ones significand, so the
        // renormalized value is a power of two and the shift loses nothing.
        frac     = carry ? m25_q[23:1] : m25_q[22:0];
        e        = exp_q + $signed({9'd0, carry});
        res_data = {mant_q[27], 31'd0};
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (zero_q || !mant_q[26]) begin
            res_data = {mant_q[27], 31'd0};
        end else if (e >= 10'sd255) begin
            res_data = {mant_q[27], 8'hFF, 23'd0};
            res_ovf  = 1'b1;
        end else if (e <= 10'sd0) begin
            // Denormals are not produced; tiny results flush to signed zero.
            res_data = {mant_q[27], 31'd0};
            res_unf  = 1'b1;
        end else begin
            res_data = {mant_q[27], e[7:0], frac};
        end
    end

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            m25_q  <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_q <= mant_in;
                        exp_q  <= $signed(exp_in);
                        zero_q <= zero_in;
                    end
                end
                ROUND:   m25_q <= m25;
                ADJUST: begin
                    data_q <= res_data;
                    ovf_q  <= res_ovf;
                    unf_q  <= res_unf;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = data_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_round_pack
//   Self-checking bench for fp_round_pack: directed corner cases with constant
//   expectations, reset aborts, and randomized pairs checked against an
//   arithmetic reference model. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] mant_in;
    logic [9:0]  exp_in;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_round_pack dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .zero_in   (zero_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: returns {ovf, unf, data}. Works on the significand as an
    // integer and the discarded bits as a fraction of one ULP (in eighths).
    function automatic logic [33:0] model(input logic [27:0] m, input logic [9:0] e, input logic z);
        int unsigned sig;
        int unsigned rem;
        int          ex;
        logic        sign;
        sign = m[27];
        sig  = m[26:3];
        rem  = m[2:0];
        if (rem > 4 || (rem == 4 && sig % 2 == 1))
            sig = sig + 1;
        ex = $signed(e);
        if (sig >= 32'h0100_0000) begin
            sig = sig / 2;
            ex  = ex + 1;
        end
        if (z || !m[26])  return {2'b00, sign, 31'd0};
        if (ex >= 255)    return {2'b10, sign, 8'hFF, 23'd0};
        if (ex <= 0)      return {2'b01, sign, 31'd0};
        return {2'b00, sign, 8'(ex), 23'(sig)};
    endfunction

    // Garbage on the inputs while the block is busy; it must be ignored.
    task automatic scramble();
        in_valid = 1'($urandom);
        mant_in  = 28'($urandom);
        exp_in   = 10'($urandom);
        zero_in  = 1'($urandom);
    endtask

    // Called at a falling edge in IDLE. The handshake cycle starts at the
    // preceding rising edge N; the pair is captured at N+1 and out_valid must
    // rise after edge N+3.
    task automatic run_op(input string tag, input logic [27:0] m, input logic [9:0] e,
                          input logic z, input logic [33:0] want, input int stall);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        mant_in   = m;
        exp_in    = e;
        zero_in   = z;
        in_valid  = 1'b1;
        out_ready = 1'($urandom);
        @(negedge clk);
        check({tag, "_busy1"}, {in_ready, out_valid}, 2'b00);
        scramble();
        @(negedge clk);
        check({tag, "_busy2"}, {in_ready, out_valid}, 2'b00);
        scramble();
        @(negedge clk);
        check({tag, "_valid"}, {in_ready, out_valid}, 2'b01);
        check({tag, "_data"}, out_data, want[31:0]);
        check({tag, "_flags"}, {ovf, unf}, want[33:32]);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            scramble();
            @(negedge clk);
            check({tag, "_hold"}, {in_ready, out_valid, ovf, unf, out_data},
                  {2'b01, want[33:32], want[31:0]});
        end
        // Offer a new pair in the same cycle OUT is left: it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        check({tag, "_release"}, {in_ready, out_valid}, 2'b10);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic abort_op(input string tag, input int depth);
        mant_in  = 28'h4000000;
        exp_in   = 10'd127;
        zero_in  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < depth; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        res = 1'b0;
        #1;
        check({tag, "_rst_hs"}, {in_ready, out_valid}, 2'b10);
        check({tag, "_rst_data"}, out_data, 32'h0);
        check({tag, "_rst_flags"}, {ovf, unf}, 2'b00);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [27:0] m;
        logic [9:0]  e;
        logic        z;
        int          ev;

        res       = 1'b0;
        in_valid  = 1'b0;
        mant_in   = '0;
        exp_in    = '0;
        zero_in   = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset_hs", {in_ready, out_valid}, 2'b10);
        check("reset_data", out_data, 32'h0);
        check("reset_flags", {ovf, unf}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);

        // Directed corner cases
        run_op("one",        28'h4000000, 10'd127, 1'b0, {2'b00, 32'h3F800000}, 0);
        run_op("tie_even",   28'h4000004, 10'd127, 1'b0, {2'b00, 32'h3F800000}, 0);
        run_op("tie_odd",    28'h400000C, 10'd127, 1'b0, {2'b00, 32'h3F800002}, 0);
        run_op("carry",      28'h7FFFFFE, 10'd127, 1'b0, {2'b00, 32'h40000000}, 0);
        run_op("carry_ovf",  28'h7FFFFFE, 10'd254, 1'b0, {2'b10, 32'h7F800000}, 0);
        run_op("carry_novf", 28'hFFFFFFE, 10'd254, 1'b0, {2'b10, 32'hFF800000}, 0);
        run_op("unf_pos",    28'h4000000, 10'd0,   1'b0, {2'b01, 32'h00000000}, 0);
        run_op("unf_neg",    28'hC000000, 10'd0,   1'b0, {2'b01, 32'h80000000}, 0);
        run_op("zero_neg",   28'hC000000, 10'd127, 1'b1, {2'b00, 32'h80000000}, 0);
        run_op("backpress",  28'h4000000, 10'd127, 1'b0, {2'b00, 32'h3F800000}, 5);

        // Reset in ROUND, ADJUST and OUT, each followed by a clean transaction
        for (int d = 1; d <= 3; d++) begin
            abort_op($sformatf("abort%0d", d), d);
            run_op($sformatf("after_abort%0d", d), 28'h4000000, 10'd127, 1'b0,
                   {2'b00, 32'h3F800000}, 0);
        end

        // Randomized pairs against the reference model
        for (int n = 0; n < 200; n++) begin
            m[27]   = 1'($urandom);
            m[26]   = ($urandom_range(0, 15) != 0);
            m[25:3] = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF : 23'($urandom);
            m[2:0]  = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       ev = $urandom_range(250, 258);
                1:       ev = int'($urandom_range(0, 4)) - 2;
                2:       ev = ($urandom_range(0, 1) != 0) ? 510 : -512;
                default: ev = int'($urandom_range(0, 1022)) - 512;
            endcase
            e = 10'(ev);
            z = ($urandom_range(0, 15) == 0);
            run_op($sformatf("rand%0d", n), m, e, z, model(m, e, z), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
